// File: rtl/bfp_pkg.sv
// Shared block-floating-point definitions: exponent width helper and the
// expander's state encoding, common to the calculator, compressor and expander.
package bfp_pkg;

  typedef logic [0:0] bfp_state_t;

  localparam bfp_state_t S_WAIT_EXP = 1'b0;
  localparam bfp_state_t S_PAYLOAD  = 1'b1;

  function automatic int shift_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bfp_denorm_shift.sv
// Combinational mantissa denormaliser: left-justifies the mantissa in a
// WIDTH-bit word, then logically shifts it right by the block exponent.
module bfp_denorm_shift
  import bfp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MANT_WIDTH = 8,
  localparam int SHW       = shift_w(WIDTH)
) (
  input  logic [MANT_WIDTH-1:0] mant,
  input  logic [SHW-1:0]        shift,
  output logic [WIDTH-1:0]      data
);

  localparam logic [SHW-1:0] SHIFT_MAX = SHW'(WIDTH);

  logic [WIDTH-1:0] full_s;

  // Cast-then-shift keeps MANT_WIDTH == WIDTH legal (no zero-width pad).
  assign full_s = WIDTH'(mant) << (WIDTH - MANT_WIDTH);
  assign data   = (shift >= SHIFT_MAX) ? {WIDTH{1'b0}} : (full_s >> shift);

endmodule

// File: rtl/bfp_expander.sv
// Block-floating-point expander: pairs each block exponent with BLOCK_LEN
// mantissas, reconstructs full-width magnitudes and checks block framing.
module bfp_expander
  import bfp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MANT_WIDTH = 8,
  parameter int BLOCK_LEN  = 16,
  localparam int SHW       = shift_w(WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [SHW-1:0]        i_shift_factor,
  input  logic                  i_shift_valid,
  output logic                  o_shift_ready,
  input  logic                  i_valid,
  input  logic [MANT_WIDTH-1:0] i_mant,
  input  logic                  i_last,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_last,
  input  logic                  i_ready,
  output logic                  o_len_err,
  output logic                  o_range_err
);

  localparam int               CNT_W     = $clog2(BLOCK_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BLOCK_LEN - 1);
  localparam logic [SHW-1:0]   SHIFT_MAX = SHW'(WIDTH);

  bfp_state_t       state_r;
  logic [CNT_W-1:0] count_r;
  logic             exp_pending_r;
  logic [SHW-1:0]   exp_hold_r;
  logic [SHW-1:0]   cur_shift_r;

  logic             shift_acc_s;
  logic             shift_over_s;
  logic [SHW-1:0]   shift_clamped_s;
  logic             mant_acc_s;
  logic             cnt_end_s;
  logic             eob_s;
  logic             len_err_s;
  logic [WIDTH-1:0] denorm_data_s;

  assign o_shift_ready   = !exp_pending_r;
  assign shift_acc_s     = i_shift_valid && !exp_pending_r;
  assign shift_over_s    = i_shift_factor > SHIFT_MAX;
  assign shift_clamped_s = shift_over_s ? SHIFT_MAX : i_shift_factor;

  assign o_ready    = (state_r == S_PAYLOAD) && (!o_valid || i_ready);
  assign mant_acc_s = i_valid && o_ready;
  assign cnt_end_s  = (count_r == CNT_LAST);
  assign eob_s      = i_last || cnt_end_s;
  // Exactly one of the two end conditions means early or missing i_last.
  assign len_err_s  = i_last != cnt_end_s;

  bfp_denorm_shift #(
    .WIDTH      (WIDTH),
    .MANT_WIDTH (MANT_WIDTH)
  ) u_denorm (
    .mant  (i_mant),
    .shift (cur_shift_r),
    .data  (denorm_data_s)
  );

  // Exponent holding register, block sequencing and range-error pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r       <= S_WAIT_EXP;
      exp_pending_r <= 1'b0;
      exp_hold_r    <= {SHW{1'b0}};
      cur_shift_r   <= {SHW{1'b0}};
      o_range_err   <= 1'b0;
    end else begin
      o_range_err <= shift_acc_s && shift_over_s;
      case (state_r)
        S_WAIT_EXP: begin
          if (exp_pending_r) begin
            cur_shift_r   <= exp_hold_r;
            exp_pending_r <= 1'b0;
            state_r       <= S_PAYLOAD;
          end else if (shift_acc_s) begin
            cur_shift_r <= shift_clamped_s;
            state_r     <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (mant_acc_s && eob_s) begin
            // A ready exponent starts the next block with no bubble.
            if (exp_pending_r) begin
              cur_shift_r   <= exp_hold_r;
              exp_pending_r <= 1'b0;
            end else if (shift_acc_s) begin
              cur_shift_r <= shift_clamped_s;
            end else begin
              state_r <= S_WAIT_EXP;
            end
          end else if (shift_acc_s) begin
            exp_hold_r    <= shift_clamped_s;
            exp_pending_r <= 1'b1;
          end
        end
        default: begin
          state_r <= S_WAIT_EXP;
        end
      endcase
    end
  end

  // Sample counter and registered output stage with backpressure hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_r   <= {CNT_W{1'b0}};
      o_valid   <= 1'b0;
      o_data    <= {WIDTH{1'b0}};
      o_last    <= 1'b0;
      o_len_err <= 1'b0;
    end else begin
      o_len_err <= mant_acc_s && len_err_s;
      if (mant_acc_s) begin
        o_valid <= 1'b1;
        o_data  <= denorm_data_s;
        o_last  <= eob_s;
        count_r <= eob_s ? {CNT_W{1'b0}} : (count_r + CNT_W'(1));
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bfp_expander.sv
// Directed scoreboard bench for bfp_expander (WIDTH=16, MANT_WIDTH=8, BLOCK_LEN=4).
module tb_bfp_expander;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [4:0]  i_shift_factor = 5'd0;
  logic        i_shift_valid = 1'b0;
  logic        o_shift_ready;
  logic        i_valid = 1'b0;
  logic [7:0]  i_mant = 8'd0;
  logic        i_last = 1'b0;
  logic        o_ready;
  logic        o_valid;
  logic [15:0] o_data;
  logic        o_last;
  logic        i_ready = 1'b1;
  logic        o_len_err;
  logic        o_range_err;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        len_err;
  } exp_t;

  exp_t sb_q[$];
  int   exp_model_q[$];
  int   model_cnt = 0;
  int   cur_sh = 0;
  int   total = 0;
  int   bad = 0;
  int   rcv = 0;
  int   sent = 0;
  int   waits;
  int   rcv0;
  int   sent0;
  logic bp_en = 1'b0;
  logic [3:0] bp_pat = 4'b1001;
  int   bp_idx = 0;
  logic prev_v = 1'b0;
  logic prev_x = 1'b0;

  bfp_expander #(
    .WIDTH      (16),
    .MANT_WIDTH (8),
    .BLOCK_LEN  (4)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_shift_factor (i_shift_factor),
    .i_shift_valid  (i_shift_valid),
    .o_shift_ready  (o_shift_ready),
    .i_valid        (i_valid),
    .i_mant         (i_mant),
    .i_last         (i_last),
    .o_ready        (o_ready),
    .o_valid        (o_valid),
    .o_data         (o_data),
    .o_last         (o_last),
    .i_ready        (i_ready),
    .o_len_err      (o_len_err),
    .o_range_err    (o_range_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send_exp(input int sh);
    int n;
    i_shift_valid  = 1'b1;
    i_shift_factor = sh[4:0];
    n = 0;
    forever begin
      @(negedge i_clk);
      if (o_shift_ready) break;
      n++;
      if (n > 50) break;
    end
    if (n > 50) begin
      chk("exp_accept_timeout", 32'(n), 32'd0);
    end else begin
      exp_model_q.push_back((sh > 16) ? 16 : sh);
    end
    @(posedge i_clk);
    #1;
    i_shift_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] mant, input logic last, output int nwait);
    logic [15:0] full;
    exp_t e;
    logic eob;
    i_valid = 1'b1;
    i_mant  = mant;
    i_last  = last;
    nwait   = 0;
    forever begin
      @(negedge i_clk);
      if (o_ready) break;
      nwait++;
      if (nwait > 50) break;
    end
    if (nwait > 50) begin
      chk("beat_accept_timeout", 32'(nwait), 32'd0);
    end else begin
      if (model_cnt == 0) begin
        if (exp_model_q.size() == 0) cur_sh = 0;
        else cur_sh = exp_model_q.pop_front();
      end
      full      = {mant, 8'h00};
      e.data    = (cur_sh >= 16) ? 16'h0000 : (full >> cur_sh);
      eob       = last || (model_cnt == 3);
      e.last    = eob;
      e.len_err = (last && model_cnt < 3) || (model_cnt == 3 && !last);
      model_cnt = eob ? 0 : model_cnt + 1;
      sb_q.push_back(e);
      sent++;
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sb_q.size() != 0; k++) @(posedge i_clk);
    #1;
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  // Output monitor: compares every presented beat against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        prev_v = 1'b0;
        prev_x = 1'b0;
      end else begin
        if (o_valid) begin
          if (sb_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL unexpected_out observed=%0h expected=none", o_data);
          end else begin
            e = sb_q[0];
            chk("o_data", 32'(o_data), 32'(e.data));
            chk("o_last", 32'(o_last), 32'(e.last));
            if (prev_x || !prev_v) chk("o_len_err", 32'(o_len_err), 32'(e.len_err));
            else chk("o_len_err_hold", 32'(o_len_err), 32'd0);
            if (!i_ready) chk("o_ready_stall", 32'(o_ready), 32'd0);
            if (i_ready) begin
              void'(sb_q.pop_front());
              rcv++;
            end
          end
        end else begin
          chk("o_len_err_idle", 32'(o_len_err), 32'd0);
        end
        prev_v = o_valid;
        prev_x = o_valid && i_ready;
      end
    end
  end

  // Downstream ready pattern 1,0,0,1 while backpressure is enabled.
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      if (bp_en) begin
        i_ready = bp_pat[bp_idx];
        bp_idx  = (bp_idx + 1) % 4;
      end else begin
        i_ready = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $error("FAIL watchdog observed=timeout expected=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #12;
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_data", 32'(o_data), 32'd0);
    chk("rst_o_last", 32'(o_last), 32'd0);
    chk("rst_o_len_err", 32'(o_len_err), 32'd0);
    chk("rst_o_range_err", 32'(o_range_err), 32'd0);
    chk("rst_o_shift_ready", 32'(o_shift_ready), 32'd1);
    chk("rst_o_ready", 32'(o_ready), 32'd0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Basic reconstruction, plus back-to-back with exponent 4 held pending
    send_exp(0);
    chk("range_err_ok", 32'(o_range_err), 32'd0);
    send_exp(4);
    i_shift_valid  = 1'b1;
    i_shift_factor = 5'd9;
    @(negedge i_clk);
    chk("shift_ready_pending", 32'(o_shift_ready), 32'd0);
    @(posedge i_clk);
    #1;
    i_shift_valid = 1'b0;
    send_beat(8'hA5, 1'b0, waits);
    chk("latency_valid", 32'(o_valid), 32'd1);
    chk("latency_data", 32'(o_data), 32'h0000A500);
    send_beat(8'h01, 1'b0, waits);
    send_beat(8'hFF, 1'b0, waits);
    send_beat(8'h80, 1'b1, waits);
    send_beat(8'hA5, 1'b0, waits);
    chk("b2b_no_bubble", 32'(waits), 32'd0);
    chk("b2b_data", 32'(o_data), 32'h00000A50);
    send_beat(8'h12, 1'b0, waits);
    send_beat(8'h34, 1'b0, waits);
    send_beat(8'h56, 1'b1, waits);
    idle();
    drain();

    // Shift 3 (single truncated beat), shift 16 and out-of-range 17
    send_exp(3);
    send_beat(8'hA5, 1'b1, waits);
    chk("shift3_data", 32'(o_data), 32'h000014A0);
    idle();
    send_exp(16);
    for (int i = 0; i < 4; i++) send_beat(8'hFF, (i == 3), waits);
    idle();
    send_exp(17);
    chk("range_err_pulse", 32'(o_range_err), 32'd1);
    @(posedge i_clk);
    #1;
    chk("range_err_clear", 32'(o_range_err), 32'd0);
    for (int i = 0; i < 4; i++) send_beat(8'hC3, (i == 3), waits);
    idle();
    drain();

    // Framing: early i_last, then missing i_last
    send_exp(0);
    send_beat(8'h11, 1'b0, waits);
    send_beat(8'h22, 1'b1, waits);
    idle();
    send_exp(2);
    for (int i = 0; i < 4; i++) send_beat(8'(8'h30 + i), 1'b0, waits);
    idle();
    drain();

    // Backpressure over 3 blocks
    rcv0  = rcv;
    sent0 = sent;
    bp_en = 1'b1;
    for (int b = 0; b < 3; b++) begin
      send_exp(b);
      for (int i = 0; i < 4; i++) send_beat(8'($urandom_range(255)), (i == 3), waits);
      idle();
    end
    drain();
    bp_en = 1'b0;
    chk("bp_count", 32'(rcv - rcv0), 32'(sent - sent0));
    chk("bp_count_abs", 32'(rcv - rcv0), 32'd12);
    @(posedge i_clk);
    #1;

    // Reset mid-block with a pending exponent
    send_exp(0);
    send_beat(8'h44, 1'b0, waits);
    send_beat(8'h55, 1'b0, waits);
    idle();
    send_exp(5);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_o_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_o_data", 32'(o_data), 32'd0);
    chk("mid_rst_o_last", 32'(o_last), 32'd0);
    chk("mid_rst_o_shift_ready", 32'(o_shift_ready), 32'd1);
    sb_q.delete();
    exp_model_q.delete();
    model_cnt = 0;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    chk("post_rst_o_ready", 32'(o_ready), 32'd0);
    send_exp(1);
    for (int i = 0; i < 4; i++) send_beat(8'(8'h60 + i), (i == 3), waits);
    idle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
